// File: rtl/ctrl_packet_injector.sv
// Purpose: inject host register read/write control packets into empty forward slots; optional stats via CTRL_INJECTOR_STATS_EN.
// Latency: Back_* and Front_Instruction* are 1 cycle behind their inputs; request handshake to Back_* is at least 2 cycles.
// Backpressure: Req_Ready drops while the request FIFO is full or in reset; upstream traffic always wins the slot.

// Small generic FIFO: registered storage, level counter, no bypass.
// Latency: an entry is visible at the head the cycle after its push.
// Backpressure: push_rdy is low when full (even if a pop happens that cycle) and during reset.
module ctrl_packet_injector_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Full check uses the start-of-cycle count, so a same-cycle pop never frees room early.
    assign push_rdy = !rst && (count != LW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];
    assign level    = count;

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LW'(1);
            end
        end
    end

endmodule

module ctrl_packet_injector #(
    parameter int DATA_WIDTH                  = 512,
    parameter int STREAM_ID_NUM               = 16,
    parameter int CHUNK_ID_NUM                = 32,
    parameter int CHANNEL_ID_NUM              = 1024,
    parameter int STATE_WIDTH                 = 32,
    parameter int INSTRUCTION_WIDTH           = 3,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter int FIFO_DEPTH                  = 4,
    parameter int CTRL_STREAM_ID              = 0,
    localparam int STREAM_ID_WIDTH            = $clog2(STREAM_ID_NUM),
    localparam int CHUNK_ID_WIDTH             = $clog2(CHUNK_ID_NUM),
    localparam int CHANNEL_ID_WIDTH           = $clog2(CHANNEL_ID_NUM),
    localparam int LEVEL_WIDTH                = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [DATA_WIDTH-1:0]                  Front_Data,
    input  logic [1:0]                             Front_Type,
    input  logic                                   Front_Last,
    input  logic [STREAM_ID_WIDTH-1:0]             Front_StreamID,
    input  logic [CHUNK_ID_WIDTH-1:0]              Front_ChunkID,
    input  logic [CHANNEL_ID_WIDTH-1:0]            Front_ChannelID,
    input  logic [STATE_WIDTH-1:0]                 Front_State,

    output logic [DATA_WIDTH-1:0]                  Back_Data,
    output logic [1:0]                             Back_Type,
    output logic                                   Back_Last,
    output logic [STREAM_ID_WIDTH-1:0]             Back_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]              Back_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0]            Back_ChannelID,
    output logic [STATE_WIDTH-1:0]                 Back_State,

    input  logic [INSTRUCTION_WIDTH-1:0]           Back_InstructionType,
    input  logic [STREAM_ID_WIDTH-1:0]             Back_InstructionStreamID,
    input  logic [CHANNEL_ID_WIDTH-1:0]            Back_InstructionChannelID,
    input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Back_InstructionParameter,

    output logic [INSTRUCTION_WIDTH-1:0]           Front_InstructionType,
    output logic [STREAM_ID_WIDTH-1:0]             Front_InstructionStreamID,
    output logic [CHANNEL_ID_WIDTH-1:0]            Front_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Front_InstructionParameter,

    input  logic                                   Req_Valid,
    output logic                                   Req_Ready,
    input  logic                                   Req_Write,
    input  logic [CHANNEL_ID_WIDTH-1:0]            Req_Target,
    input  logic [STATE_WIDTH-1:0]                 Req_Addr,
    input  logic [31:0]                            Req_WData,
`ifdef CTRL_INJECTOR_STATS_EN
    output logic [31:0]                            Stat_Injected,
    output logic [31:0]                            Stat_StallCycles,
`endif
    output logic [LEVEL_WIDTH-1:0]                 Fifo_Level
);

    // One FIFO entry: {write flag, target hop count, register address, write data}.
    localparam int REQ_WIDTH = 1 + CHANNEL_ID_WIDTH + STATE_WIDTH + 32;
    localparam int WORDS     = DATA_WIDTH / 32;

    logic [REQ_WIDTH-1:0]        req_dat;
    logic [REQ_WIDTH-1:0]        head_dat;
    logic                        head_vld;
    logic                        head_write;
    logic [CHANNEL_ID_WIDTH-1:0] head_target;
    logic [STATE_WIDTH-1:0]      head_addr;
    logic [31:0]                 head_wdata;
    logic                        slot_empty;
    logic                        inject;
    logic [CHUNK_ID_WIDTH-1:0]   inj_chunk;
    logic [DATA_WIDTH-1:0]       inj_data;

    assign req_dat = {Req_Write, Req_Target, Req_Addr, Req_WData};
    assign {head_write, head_target, head_addr, head_wdata} = head_dat;

    // Only a truly idle upstream cycle is a free slot; any non-zero Type passes through.
    assign slot_empty = (Front_Type == 2'b00);
    assign inject     = slot_empty && head_vld;

    ctrl_packet_injector_fifo #(
        .WIDTH (REQ_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (Req_Valid),
        .push_rdy (Req_Ready),
        .push_dat (req_dat),
        .pop_rdy  (inject),
        .pop_vld  (head_vld),
        .pop_dat  (head_dat),
        .level    (Fifo_Level)
    );

    // Build the injected ChunkID (relative-addressing MSB, opcode in bit 0) and payload.
    always_comb begin
        inj_chunk                   = '0;
        inj_chunk[CHUNK_ID_WIDTH-1] = 1'b1;
        inj_chunk[0]                = head_write;
        inj_data                    = head_write ? {WORDS{head_wdata}} : '0;
    end

    // Forward register: pass upstream traffic, else fill an empty slot, else emit an idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Back_Data      <= '0;
            Back_Type      <= 2'b00;
            Back_Last      <= 1'b0;
            Back_StreamID  <= '0;
            Back_ChunkID   <= '0;
            Back_ChannelID <= '0;
            Back_State     <= '0;
        end else if (!slot_empty) begin
            Back_Data      <= Front_Data;
            Back_Type      <= Front_Type;
            Back_Last      <= Front_Last;
            Back_StreamID  <= Front_StreamID;
            Back_ChunkID   <= Front_ChunkID;
            Back_ChannelID <= Front_ChannelID;
            Back_State     <= Front_State;
        end else if (inject) begin
            Back_Data      <= inj_data;
            Back_Type      <= 2'b10;
            Back_Last      <= 1'b1;
            Back_StreamID  <= STREAM_ID_WIDTH'(CTRL_STREAM_ID);
            Back_ChunkID   <= inj_chunk;
            Back_ChannelID <= head_target;
            Back_State     <= head_addr;
        end else begin
            // Idle: only Type is cleared, the remaining fields keep their last value.
            Back_Type      <= 2'b00;
        end
    end

    // Backward instruction path: one register stage, no interpretation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Front_InstructionType      <= '0;
            Front_InstructionStreamID  <= '0;
            Front_InstructionChannelID <= '0;
            Front_InstructionParameter <= '0;
        end else begin
            Front_InstructionType      <= Back_InstructionType;
            Front_InstructionStreamID  <= Back_InstructionStreamID;
            Front_InstructionChannelID <= Back_InstructionChannelID;
            Front_InstructionParameter <= Back_InstructionParameter;
        end
    end

`ifdef CTRL_INJECTOR_STATS_EN
    // Injection count wraps; stall count saturates and counts cycles a queued request lost the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stat_Injected    <= '0;
            Stat_StallCycles <= '0;
        end else begin
            if (inject) begin
                Stat_Injected <= Stat_Injected + 32'd1;
            end
            if (head_vld && !slot_empty && (Stat_StallCycles != 32'hFFFF_FFFF)) begin
                Stat_StallCycles <= Stat_StallCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_packet_injector.sv
`timescale 1ns/1ps
module tb_ctrl_packet_injector;

    localparam int DW    = 512;
    localparam int SW    = 4;
    localparam int CW    = 5;
    localparam int HW    = 10;
    localparam int STW   = 32;
    localparam int IW    = 3;
    localparam int IPW   = 16;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [1:0]     typ;
        logic           last;
        logic [SW-1:0]  sid;
        logic [CW-1:0]  cid;
        logic [HW-1:0]  chan;
        logic [STW-1:0] state;
    } pkt_t;

    typedef struct packed {
        logic           wr;
        logic [HW-1:0]  target;
        logic [STW-1:0] addr;
        logic [31:0]    wdata;
    } req_t;

    typedef struct {
        logic [1:0]    ft;
        logic          rv;
        req_t          r;
        logic [LW-1:0] exp_level;
        logic          exp_rdy;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  Front_Data;
    logic [1:0]     Front_Type;
    logic           Front_Last;
    logic [SW-1:0]  Front_StreamID;
    logic [CW-1:0]  Front_ChunkID;
    logic [HW-1:0]  Front_ChannelID;
    logic [STW-1:0] Front_State;
    logic [DW-1:0]  Back_Data;
    logic [1:0]     Back_Type;
    logic           Back_Last;
    logic [SW-1:0]  Back_StreamID;
    logic [CW-1:0]  Back_ChunkID;
    logic [HW-1:0]  Back_ChannelID;
    logic [STW-1:0] Back_State;
    logic [IW-1:0]  Back_InstructionType;
    logic [SW-1:0]  Back_InstructionStreamID;
    logic [HW-1:0]  Back_InstructionChannelID;
    logic [IPW-1:0] Back_InstructionParameter;
    logic [IW-1:0]  Front_InstructionType;
    logic [SW-1:0]  Front_InstructionStreamID;
    logic [HW-1:0]  Front_InstructionChannelID;
    logic [IPW-1:0] Front_InstructionParameter;
    logic           Req_Valid;
    logic           Req_Ready;
    logic           Req_Write;
    logic [HW-1:0]  Req_Target;
    logic [STW-1:0] Req_Addr;
    logic [31:0]    Req_WData;
    logic [LW-1:0]  Fifo_Level;
`ifdef CTRL_INJECTOR_STATS_EN
    logic [31:0]    Stat_Injected;
    logic [31:0]    Stat_StallCycles;
`endif

    ctrl_packet_injector dut (
        .clk                        (clk),
        .rst                        (rst),
        .Front_Data                 (Front_Data),
        .Front_Type                 (Front_Type),
        .Front_Last                 (Front_Last),
        .Front_StreamID             (Front_StreamID),
        .Front_ChunkID              (Front_ChunkID),
        .Front_ChannelID            (Front_ChannelID),
        .Front_State                (Front_State),
        .Back_Data                  (Back_Data),
        .Back_Type                  (Back_Type),
        .Back_Last                  (Back_Last),
        .Back_StreamID              (Back_StreamID),
        .Back_ChunkID               (Back_ChunkID),
        .Back_ChannelID             (Back_ChannelID),
        .Back_State                 (Back_State),
        .Back_InstructionType       (Back_InstructionType),
        .Back_InstructionStreamID   (Back_InstructionStreamID),
        .Back_InstructionChannelID  (Back_InstructionChannelID),
        .Back_InstructionParameter  (Back_InstructionParameter),
        .Front_InstructionType      (Front_InstructionType),
        .Front_InstructionStreamID  (Front_InstructionStreamID),
        .Front_InstructionChannelID (Front_InstructionChannelID),
        .Front_InstructionParameter (Front_InstructionParameter),
        .Req_Valid                  (Req_Valid),
        .Req_Ready                  (Req_Ready),
        .Req_Write                  (Req_Write),
        .Req_Target                 (Req_Target),
        .Req_Addr                   (Req_Addr),
        .Req_WData                  (Req_WData),
`ifdef CTRL_INJECTOR_STATS_EN
        .Stat_Injected              (Stat_Injected),
        .Stat_StallCycles           (Stat_StallCycles),
`endif
        .Fifo_Level                 (Fifo_Level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    req_t mq[$];          // reference request FIFO
    pkt_t sb[$];          // expected Back_* per cycle
    pkt_t last_pkt;
    int   m_inj   = 0;
    int   m_stall = 0;
    logic fixed_instr = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic pkt_t inj_pkt(input req_t r);
        pkt_t p;
        p       = '0;
        p.typ   = 2'b10;
        p.last  = 1'b1;
        p.sid   = '0;
        p.cid   = {1'b1, 3'b000, r.wr};
        p.chan  = r.target;
        p.state = r.addr;
        for (int w = 0; w < DW / 32; w++) p.data[w*32 +: 32] = r.wr ? r.wdata : 32'h0;
        return p;
    endfunction

    // One clock cycle: drive, model, clock, compare.
    task automatic tick(input logic [1:0] ft, input logic rv, input req_t r);
        pkt_t fp, ex, got;
        int   sz0;
        logic acc;
        logic [IW-1:0]  it;
        logic [SW-1:0]  isd;
        logic [HW-1:0]  ich;
        logic [IPW-1:0] ipa;
        for (int w = 0; w < DW / 32; w++) fp.data[w*32 +: 32] = $urandom;
        fp.typ   = ft;
        fp.last  = 1'($urandom);
        fp.sid   = SW'($urandom);
        fp.cid   = CW'($urandom);
        fp.chan  = HW'($urandom);
        fp.state = $urandom;
        Front_Data = fp.data; Front_Type = fp.typ; Front_Last = fp.last;
        Front_StreamID = fp.sid; Front_ChunkID = fp.cid;
        Front_ChannelID = fp.chan; Front_State = fp.state;
        Req_Valid = rv; Req_Write = r.wr; Req_Target = r.target;
        Req_Addr = r.addr; Req_WData = r.wdata;
        if (!fixed_instr) begin
            Back_InstructionType      = IW'($urandom);
            Back_InstructionStreamID  = SW'($urandom);
            Back_InstructionChannelID = HW'($urandom);
            Back_InstructionParameter = IPW'($urandom);
        end
        it = Back_InstructionType; isd = Back_InstructionStreamID;
        ich = Back_InstructionChannelID; ipa = Back_InstructionParameter;
        #1;
        sz0 = mq.size();
        check("req_ready", DW'(Req_Ready), DW'(sz0 != DEPTH));
        acc = rv && (sz0 != DEPTH);
        if (ft != 2'b00) begin
            ex = fp;
            if (sz0 != 0) m_stall++;
        end else if (sz0 != 0) begin
            ex = inj_pkt(mq.pop_front());
            m_inj++;
        end else begin
            ex     = last_pkt;
            ex.typ = 2'b00;
        end
        if (acc) mq.push_back(r);
        sb.push_back(ex);
        last_pkt = ex;
        @(posedge clk);
        #1;
        got.data = Back_Data; got.typ = Back_Type; got.last = Back_Last;
        got.sid = Back_StreamID; got.cid = Back_ChunkID;
        got.chan = Back_ChannelID; got.state = Back_State;
        ex = sb.pop_front();
        check("back_data", got.data, ex.data);
        check("back_hdr", DW'({got.typ, got.last, got.sid, got.cid, got.chan, got.state}),
                          DW'({ex.typ, ex.last, ex.sid, ex.cid, ex.chan, ex.state}));
        check("fifo_level", DW'(Fifo_Level), DW'(mq.size()));
        check("instr", DW'({Front_InstructionType, Front_InstructionStreamID,
                            Front_InstructionChannelID, Front_InstructionParameter}),
                       DW'({it, isd, ich, ipa}));
`ifdef CTRL_INJECTOR_STATS_EN
        check("stat_injected", DW'(Stat_Injected), DW'(m_inj));
        check("stat_stall", DW'(Stat_StallCycles), DW'(m_stall));
`endif
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        last_pkt = '0;
        m_inj    = 0;
        m_stall  = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        req_t r, rz;
        logic [DW-1:0] exp_d;
        rz = '0;

        // Stimulus table: push four behind busy traffic, pop at full, push+pop at level 2.
        vecs[0]  = '{ft: 2'b01, rv: 1'b1, r: '0, exp_level: 3'd1, exp_rdy: 1'b1};
        vecs[1]  = '{ft: 2'b01, rv: 1'b1, r: '0, exp_level: 3'd2, exp_rdy: 1'b1};
        vecs[2]  = '{ft: 2'b01, rv: 1'b1, r: '0, exp_level: 3'd3, exp_rdy: 1'b1};
        vecs[3]  = '{ft: 2'b01, rv: 1'b1, r: '0, exp_level: 3'd4, exp_rdy: 1'b0};
        vecs[4]  = '{ft: 2'b00, rv: 1'b1, r: '0, exp_level: 3'd3, exp_rdy: 1'b1};
        vecs[5]  = '{ft: 2'b01, rv: 1'b0, r: '0, exp_level: 3'd3, exp_rdy: 1'b1};
        vecs[6]  = '{ft: 2'b00, rv: 1'b0, r: '0, exp_level: 3'd2, exp_rdy: 1'b1};
        vecs[7]  = '{ft: 2'b00, rv: 1'b1, r: '0, exp_level: 3'd2, exp_rdy: 1'b1};
        vecs[8]  = '{ft: 2'b10, rv: 1'b0, r: '0, exp_level: 3'd2, exp_rdy: 1'b1};
        vecs[9]  = '{ft: 2'b00, rv: 1'b0, r: '0, exp_level: 3'd1, exp_rdy: 1'b1};
        vecs[10] = '{ft: 2'b11, rv: 1'b0, r: '0, exp_level: 3'd1, exp_rdy: 1'b1};
        vecs[11] = '{ft: 2'b00, rv: 1'b0, r: '0, exp_level: 3'd0, exp_rdy: 1'b1};
        for (int i = 0; i < 12; i++) begin
            vecs[i].r.wr     = 1'(i);
            vecs[i].r.target = HW'(20 + i);
            vecs[i].r.addr   = 32'h100 + i;
            vecs[i].r.wdata  = $urandom;
        end

        // Reset state
        rst = 1'b1;
        Front_Data = '0; Front_Type = 2'b00; Front_Last = 1'b0; Front_StreamID = '0;
        Front_ChunkID = '0; Front_ChannelID = '0; Front_State = '0;
        Back_InstructionType = 3'd5; Back_InstructionStreamID = '0;
        Back_InstructionChannelID = '0; Back_InstructionParameter = '0;
        Req_Valid = 1'b0; Req_Write = 1'b0; Req_Target = '0; Req_Addr = '0; Req_WData = '0;
        model_clear();
        #13;
        check("rst_back_type", DW'(Back_Type), DW'(0));
        check("rst_back_data", Back_Data, '0);
        check("rst_level", DW'(Fifo_Level), DW'(0));
        check("rst_ready", DW'(Req_Ready), DW'(0));
        check("rst_instr_type", DW'(Front_InstructionType), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write into an idle stream: appears two cycles after the handshake
        r = '{wr: 1'b1, target: 10'd3, addr: 32'h10, wdata: 32'hDEADBEEF};
        tick(2'b00, 1'b1, r);
        check("wr_not_early", DW'(Back_Type), DW'(0));
        tick(2'b00, 1'b0, rz);
        for (int w = 0; w < DW / 32; w++) exp_d[w*32 +: 32] = 32'hDEADBEEF;
        check("wr_type", DW'(Back_Type), DW'(2'b10));
        check("wr_chunk", DW'(Back_ChunkID), DW'(5'b10001));
        check("wr_chan", DW'(Back_ChannelID), DW'(3));
        check("wr_state", DW'(Back_State), DW'(32'h10));
        check("wr_last_sid", DW'({Back_Last, Back_StreamID}), DW'(5'b1_0000));
        check("wr_data", Back_Data, exp_d);

        // Queued read waits behind ten data cycles
        pulse_reset();
        r = '{wr: 1'b0, target: 10'd5, addr: 32'h20, wdata: 32'h12345678};
        tick(2'b00, 1'b1, r);
        for (int i = 0; i < 10; i++) tick(2'b01, 1'b0, rz);
        check("rd_waiting_level", DW'(Fifo_Level), DW'(1));
`ifdef CTRL_INJECTOR_STATS_EN
        check("rd_stall_10", DW'(Stat_StallCycles), DW'(10));
`endif
        tick(2'b00, 1'b0, rz);
        check("rd_type", DW'(Back_Type), DW'(2'b10));
        check("rd_chunk", DW'(Back_ChunkID), DW'(5'b10000));
        check("rd_data_zero", Back_Data, '0);
`ifdef CTRL_INJECTOR_STATS_EN
        check("rd_injected_1", DW'(Stat_Injected), DW'(1));
`endif

        // Table-driven fill / full / push+pop sequence
        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].ft, vecs[i].rv, vecs[i].r);
            check($sformatf("vec%0d_level", i), DW'(Fifo_Level), DW'(vecs[i].exp_level));
            check($sformatf("vec%0d_ready", i), DW'(Req_Ready), DW'(vecs[i].exp_rdy));
        end

        // Pointer wrap: 20 back-to-back push/pop, then random traffic and drain
        for (int i = 0; i < 20; i++) begin
            r = '{wr: 1'(i), target: HW'(i), addr: 32'h200 + i, wdata: $urandom};
            tick(2'b00, 1'b1, r);
        end
        for (int i = 0; i < 80; i++) begin
            r = '{wr: 1'($urandom), target: HW'($urandom), addr: $urandom, wdata: $urandom};
            tick(($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                 1'($urandom), r);
        end
        for (int i = 0; i < 8 && mq.size() != 0; i++) tick(2'b00, 1'b0, rz);
        check("drain_level", DW'(Fifo_Level), DW'(0));

        // Asynchronous reset mid-stream at level 3
        for (int i = 0; i < 3; i++) begin
            r = '{wr: 1'b1, target: HW'(i), addr: 32'h300 + i, wdata: $urandom};
            tick(2'b01, 1'b1, r);
        end
        check("pre_rst_level", DW'(Fifo_Level), DW'(3));
        #3;
        rst = 1'b1;
        #1;
        check("arst_back_type", DW'(Back_Type), DW'(0));
        check("arst_level", DW'(Fifo_Level), DW'(0));
        check("arst_ready", DW'(Req_Ready), DW'(0));
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(2'b00, 1'b0, rz);
        check("post_rst_idle", DW'(Back_Type), DW'(0));

        // Instruction path pass-through
        fixed_instr = 1'b1;
        Back_InstructionType      = 3'd2;
        Back_InstructionStreamID  = 4'd1;
        Back_InstructionChannelID = 10'd7;
        Back_InstructionParameter = 16'h00AB;
        tick(2'b00, 1'b0, rz);
        check("instr_type", DW'(Front_InstructionType), DW'(3'd2));
        check("instr_chan", DW'(Front_InstructionChannelID), DW'(10'd7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_packet_injector.md
# ctrl_packet_injector

Forward-path source stage at the head of a processing chain. It injects host-issued relative-addressed control packets (CTRL_READ_REQUEST_32b / CTRL_WRITE_32b) into the forward stream, using only empty slots. Upstream data and control packets pass through untouched with one register stage. Backward-path instructions are registered and passed upstream unchanged.

## Interface
- DATA_WIDTH, 512, forward data width, multiple of 32
- STREAM_ID_NUM, 16, number of virtual streams; STREAM_ID_WIDTH = $clog2
- CHUNK_ID_NUM, 32, chunk IDs per packet; CHUNK_ID_WIDTH = $clog2
- CHANNEL_ID_NUM, 1024, channels per stream; CHANNEL_ID_WIDTH = $clog2
- STATE_WIDTH, 32, state/address field width
- INSTRUCTION_WIDTH, 3 / INSTRUCTION_PARAMETER_WIDTH, 16, backward instruction widths
- FIFO_DEPTH, 4, request FIFO entries, power of two, ≥2
- CTRL_STREAM_ID, 0, StreamID stamped on injected packets
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Front_Data/Type/Last/StreamID/ChunkID/ChannelID/State  in  per params (Type 2)  upstream forward packet
- Back_Data/Type/Last/StreamID/ChunkID/ChannelID/State  out  per params  downstream forward packet, registered
- Back_InstructionType/StreamID/ChannelID/Parameter  in  per params  instruction from downstream
- Front_InstructionType/StreamID/ChannelID/Parameter  out  per params  instruction to upstream, registered
- Req_Valid  in  1  host request valid
- Req_Ready  out  1  FIFO can accept
- Req_Write  in  1  1 = CTRL_WRITE_32b, 0 = CTRL_READ_REQUEST_32b
- Req_Target  in  CHANNEL_ID_WIDTH  hop count to target module (0 = first downstream module)
- Req_Addr  in  STATE_WIDTH  register address
- Req_WData  in  32  write value
- Fifo_Level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Request FIFO: push on Req_Valid && Req_Ready. Req_Ready = !rst && (Fifo_Level != FIFO_DEPTH). Entries are held in FIFO order.
- Slot rule: a cycle is empty when Front_Type == 2'b00. Injection happens only in an empty cycle, and only when the FIFO is non-empty at the start of that cycle. Injection pops the head.
- Injected packet fields:
  - Type = 2'b10, Last = 1, StreamID = CTRL_STREAM_ID
  - ChunkID MSB = 1 (relative addressing); ChunkID low bits = 0 for read, 1 for write
  - ChannelID = Req_Target; State = Req_Addr
  - Data = Req_WData replicated into all DATA_WIDTH/32 fields for a write; all zeros for a read
- Any non-empty Front cycle (data, control, or Type 2'b11) is copied field-for-field to Back_* next cycle. The injector never modifies or counts itself as a hop.
- Empty cycle with empty FIFO: Back_Type = 0. The other Back_* fields hold their previous values.
- Instruction path: Front_Instruction* <= Back_Instruction* every cycle, no interpretation.
- Push and pop in the same cycle: allowed when not full. Level is unchanged. A pushed entry is never popped in its own push cycle.
- Full: Req_Ready is low, including in a cycle where a pop occurs.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Back_* latency: 1 cycle from Front_*. Front_Instruction* latency: 1 cycle from Back_Instruction*.
- Minimum request-to-Back latency: handshake in cycle N, Back_Type = 2'b10 in cycle N+2, given an empty slot in N+1.
- Fifo_Level updates the cycle after push/pop.
- Reset (asynchronous, also mid-operation):
  - All Back_* = 0 (Back_Type = 0)
  - Front_InstructionType = 0 (IDLE); other Front_Instruction* = 0
  - FIFO flushed, Fifo_Level = 0, Req_Ready = 0 while rst is high
  - Pending requests are lost
- First push is possible on the first clk edge after rst deasserts.

## Configuration
- CTRL_INJECTOR_STATS_EN defined: adds outputs
  - Stat_Injected [31:0]: increments on every injection, wraps
  - Stat_StallCycles [31:0]: increments each cycle the FIFO is non-empty and Front_Type != 0; saturates at all-ones
  - Both reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then one write (Target=3, Addr=0x10, WData=0xDEADBEEF), Front_Type held 0 -> Back_Type=2'b10, ChunkID=5'b10001, ChannelID=3, State=0x10, all 16 data words 0xDEADBEEF, two cycles after handshake.
- Front_Type=2'b01 for 10 cycles with one read queued -> 10 data packets pass unchanged at 1-cycle latency. The read (ChunkID=5'b10000, Data=0) appears in the cycle after the first empty slot. Stat_StallCycles=10 with macro on.
- Push 4 requests with upstream busy -> Req_Ready=0 at level 4. One empty slot -> level 3, Req_Ready=1. Injection order matches push order.
- Push and pop in the same cycle at level 2 -> level stays 2. Run a 20-push/20-pop sequence to cover pointer wrap; FIFO order is preserved.
- Assert rst mid-stream with level 3 -> Back_Type=0 and Fifo_Level=0 immediately. Nothing is injected after release until a new push.
- Drive Back_InstructionType=3'd2, ChannelID=7 -> Front_InstructionType=3'd2, ChannelID=7 one cycle later.
